// File: rtl/pipe_t.sv
// Packed obstacle-pipe record shared by the game logic and pipes_list.
package pipe_t_pkg;

    typedef struct packed {
        logic [9:0] x;      // horizontal position
        logic [7:0] gap_y;  // vertical centre of the gap
    } pipe_t;

endpackage

// File: rtl/pipes_list.sv
// Fixed-capacity, oldest-first list of pipe_t records with tail append and an
// in-place read-modify-write pass. Define PIPES_LIST_ASSERT_EN for misuse checks.
module pipes_list
    import pipe_t_pkg::*;
#(
    parameter int CAPACITY = 16,
    parameter int PIPE_W   = $bits(pipe_t)
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  ce,
    output logic [4:0] count,
    input  logic  insert_en,
    input  pipe_t insert_data,
    input  logic  iter_start,
    output logic  iter_done,
    input  pipe_t iter_in,
    output pipe_t iter_out,
    input  logic  iter_remove
);

    localparam int         AW   = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
    localparam logic [4:0] CAP5 = 5'(CAPACITY);

    logic [PIPE_W-1:0] mem [0:CAPACITY-1];

    logic       busy;
    logic [4:0] rd;
    logic [4:0] wr;

    logic              mem_we;
    logic [4:0]        mem_waddr;
    logic [PIPE_W-1:0] mem_wdata;
    logic              last_visit;
    logic [4:0]        wr_next;

    assign iter_done  = !busy;
    assign iter_out   = busy ? pipe_t'(mem[rd[AW-1:0]]) : '0;
    assign last_visit = (rd == count - 5'd1);
    assign wr_next    = iter_remove ? wr : wr + 5'd1;

    // A pass writes kept entries back at wr <= rd, so compaction never
    // clobbers an entry that has not been visited yet.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (busy) begin
            mem_we    = !iter_remove;
            mem_waddr = wr;
            mem_wdata = PIPE_W'(iter_in);
        end else if (!iter_start && insert_en && (count < CAP5)) begin
            mem_we    = 1'b1;
            mem_waddr = count;
            mem_wdata = PIPE_W'(insert_data);
        end
    end

    always_ff @(posedge clk) begin
        if (ce && mem_we) begin
            mem[mem_waddr[AW-1:0]] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            busy  <= 1'b0;
            rd    <= '0;
            wr    <= '0;
        end else if (ce) begin
            if (!busy) begin
                if (iter_start) begin
                    busy <= (count != 5'd0);
                    rd   <= '0;
                    wr   <= '0;
                end else if (insert_en && (count < CAP5)) begin
                    count <= count + 5'd1;
                end
            end else begin
                wr <= wr_next;
                if (last_visit) begin
                    busy  <= 1'b0;
                    count <= wr_next;
                    rd    <= '0;
                end else begin
                    rd <= rd + 5'd1;
                end
            end
        end
    end

`ifdef PIPES_LIST_ASSERT_EN
    always_ff @(posedge clk) begin
        if (!rst && ce) begin
            if (insert_en && count == CAP5)
                $error("pipes_list: insert while full");
            if (insert_en && busy)
                $error("pipes_list: insert during a pass");
            if (iter_start && busy)
                $error("pipes_list: iter_start during a pass");
            if (count > CAP5)
                $error("pipes_list: count exceeds capacity");
        end
    end
`else
    // Misuse checks are compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_pipes_list.sv
// Self-checking bench for pipes_list against a queue-based list model.
module tb_pipes_list;
    import pipe_t_pkg::*;

    localparam int CAP = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b1;
    logic [4:0] count;
    logic       insert_en = 1'b0;
    pipe_t      insert_data = '0;
    logic       iter_start = 1'b0;
    logic       iter_done;
    pipe_t      iter_in = '0;
    pipe_t      iter_out;
    logic       iter_remove = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    pipe_t q[$];

    pipes_list #(.CAPACITY(CAP)) dut (
        .clk(clk), .rst(rst), .ce(ce), .count(count),
        .insert_en(insert_en), .insert_data(insert_data),
        .iter_start(iter_start), .iter_done(iter_done),
        .iter_in(iter_in), .iter_out(iter_out), .iter_remove(iter_remove)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_done"}, 32'(iter_done), 32'd1);
        check({tag, "_count"}, 32'(count), 32'(q.size()));
        check({tag, "_out0"}, 32'(iter_out), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        q.delete();
    endtask

    task automatic insert(input pipe_t v);
        insert_en = 1'b1;
        insert_data = v;
        tick();
        insert_en = 1'b0;
        if (q.size() < CAP) q.push_back(v);
        check("insert_count", 32'(count), 32'(q.size()));
    endtask

    // mode 0: read-through, 1: increment, 2: remove first entry, 3: random edit
    task automatic do_pass(input int mode, input bit ins_busy);
        pipe_t nq[$];
        int    n;
        bit    rem;
        pipe_t val;
        n = q.size();
        iter_start = 1'b1;
        insert_en = ins_busy;
        insert_data = pipe_t'(18'h2aaaa);
        tick();
        iter_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("pass_busy", 32'(iter_done), 32'd0);
            check("pass_out", 32'(iter_out), 32'(q[i]));
            rem = 1'b0;
            val = q[i];
            case (mode)
                1: val = pipe_t'(18'(q[i]) + 18'd1);
                2: rem = (i == 0);
                3: begin
                    rem = ($urandom_range(0, 3) == 0);
                    val = pipe_t'(18'($urandom));
                end
                default: ;
            endcase
            iter_remove = rem;
            iter_in = val;
            if (!rem) nq.push_back(val);
            tick();
        end
        iter_remove = 1'b0;
        insert_en = 1'b0;
        q = nq;
        check_idle("pass_end");
    endtask

    initial begin
        do_reset();
        check_idle("reset");

        for (int v = 1; v <= 4; v++) insert(pipe_t'(18'(v)));
        check_idle("four_inserted");

        do_pass(0, 1'b0);
        for (int k = 0; k < 4; k++) do_pass(1, 1'b0);
        do_pass(0, 1'b0);

        do_pass(2, 1'b0);
        do_pass(0, 1'b0);
        for (int k = 0; k < 3; k++) do_pass(2, 1'b0);
        check("all_removed", 32'(count), 32'd0);

        // Start on an empty list, with a concurrent insert that must be dropped
        do_pass(0, 1'b1);
        check("empty_start_count", 32'(count), 32'd0);

        for (int v = 0; v < 17; v++) insert(pipe_t'(18'(100 + v)));
        check("full_count", 32'(count), 32'd16);

        ce = 1'b0;
        iter_start = 1'b1;
        insert_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ce_hold_done", 32'(iter_done), 32'd1);
            check("ce_hold_count", 32'(count), 32'd16);
        end
        iter_start = 1'b0;
        insert_en = 1'b0;
        ce = 1'b1;
        do_pass(0, 1'b1);

        // Reset in the middle of a pass aborts it
        iter_start = 1'b1;
        tick();
        iter_start = 1'b0;
        iter_in = iter_out;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        check_idle("mid_pass_reset");

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    int burst;
                    burst = $urandom_range(1, 4);
                    for (int b = 0; b < burst; b++) insert(pipe_t'(18'($urandom)));
                end
                2: do_pass(3, 1'($urandom_range(0, 1)));
                default: do_pass(0, 1'b0);
            endcase
        end
        do_pass(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipes_list.md
Name: pipes_list

Overview:
- Fixed-capacity ordered list of pipe_t records (obstacle pipes) for the game logic.
- Supports tail append and a sequential read-modify-write pass over all entries.
- During a pass, each entry may be replaced by a caller-supplied value or removed.
- Removal compacts the list in place, so entry order stays oldest-first.

Parameters:
- CAPACITY, 16, maximum number of stored entries; must be ≤ 31 so it fits in count.
- PIPE_W, $bits(pipe_t), width of one entry; pipe_t is the packed type from pipe_t.sv.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- ce  input  1  clock enable; when low, all state holds and inputs are ignored.
- count  output  5  number of valid entries, 0..CAPACITY.
- insert_en  input  1  append insert_data at the tail this cycle.
- insert_data  input  pipe_t  entry to append.
- iter_start  input  1  one-cycle pulse that begins a pass.
- iter_done  output  1  high when no pass is in progress (level, not a pulse).
- iter_in  input  pipe_t  replacement value for the entry currently on iter_out.
- iter_out  output  pipe_t  entry currently being visited.
- iter_remove  input  1  drop the current entry instead of writing iter_in back.

Behaviour:
- Storage: mem[0..CAPACITY-1] holds valid entries in mem[0..count-1], oldest at index 0.
- Internal state: busy flag, read index rd, write index wr.
- Reset (clk edge with rst=1, regardless of ce): count=0, busy=0, rd=0, wr=0. mem contents are don't-care.
- After reset: iter_done=1, iter_out=0.
- Nothing changes on an edge where ce=0 and rst=0.
- iter_done = !busy, combinational.
- iter_out = mem[rd] while busy; 0 while idle (combinational).
- Insert, idle: if insert_en and count<CAPACITY, mem[count]<=insert_data and count<=count+1.
- Insert when full: silently dropped.
- Insert while busy, or in the same cycle as iter_start: dropped. iter_start has priority.
- Start, idle: iter_start with count>0 sets busy=1, rd=0, wr=0.
- Start with count==0: no effect; iter_done stays 1.
- iter_start while busy is ignored.
- Each busy edge visits entry rd:
  - iter_remove=0: mem[wr]<=iter_in, wr<=wr+1.
  - iter_remove=1: no write; wr unchanged.
  - rd<=rd+1 in both cases.
- Finish: on the busy edge where rd==count-1, busy<=0 and count<=final wr (wr+1 if the last entry is kept, wr if removed). Also rd<=0.
- Latency: a pass over N entries occupies exactly N cycles after the start edge. iter_done rises after the Nth visit edge.
- Write-back sees updated values on the next pass only. Because wr≤rd, compaction never overwrites an unread entry.
- Removing all entries leaves count=0.
- iter_in is sampled only on busy edges. The caller normally loops iter_in from iter_out for a pure read pass.
- Reset during a pass aborts it: count=0, busy=0.
- Widths: count is 5 bits; rd and wr are 5 bits. No wrap-around is possible given CAPACITY ≤ 31.

Optional Feature:
- Macro: PIPES_LIST_ASSERT_EN.
- Defined: simulation-only checks issue $error when any of these occurs with ce=1:
  - insert_en while count==CAPACITY.
  - insert_en while busy.
  - iter_start while busy.
  - count exceeds CAPACITY.
- Not defined: no checks are compiled. Functional behaviour is identical in both cases.

Test Plan:
- Reset, then insert_en=1 with data 1,2,3,4 on four consecutive edges -> count=4, iter_done=1.
- Pass with iter_in=iter_out -> iter_out reads 1,2,3,4 on the four cycles after start; iter_done rises after the 4th visit edge; count=4; contents unchanged.
- Four passes with iter_in=iter_out+1 -> contents 5,6,7,8. A following read pass returns 5,6,7,8 in order.
- Four passes, each with iter_remove=1 on the first visit cycle and pass-through afterwards -> count goes 3,2,1,0. After the first removal a pass reads 6,7,8.
- Start a pass with count=0 -> iter_done stays 1 on the cycle after start; count=0.
- Insert 17 values with CAPACITY=16 -> count=16, 17th dropped. Then hold ce=0 for 3 cycles with iter_start=1 -> no state change, iter_done=1.
